// File: rtl/pipe_pkg.sv
// Constants shared by the pipeline registers between fetch, decode and execute.
package pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    // MIPS sll $0,$0,0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ifb_ram.sv
// Storage array for the fetch buffer: one synchronous write port and one
// asynchronous read port, no reset (contents are don't-care until written).
module ifb_ram #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_buffer.sv
// FIFO of fetched instruction/PC pairs between IF and ID; presents a NOP
// bubble when empty and counts the bubbles handed to decode.
module instr_fetch_buffer #(
    parameter int unsigned      WIDTH = pipe_pkg::INSTR_W,
    parameter int unsigned      PC_W  = pipe_pkg::PC_W,
    parameter int unsigned      DEPTH = 4,
    parameter logic [WIDTH-1:0] NOP   = pipe_pkg::NOP_INSTR,
    parameter int unsigned      CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     in_ready,
    input  logic                     stall,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CNT_W-1:0]       bubble_q, bubble_d;
    logic                   push, pop;
    logic [WIDTH+PC_W-1:0]  head;

    // Full/empty come from the occupancy count, never from pointer equality.
    assign in_ready  = (count_q < Full);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & ~stall & ~flush;

    ifb_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DATA_W (WIDTH + PC_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({in_instr, in_pc}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bubble_d = bubble_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Flush cycles with an empty head still hand decode a bubble.
        if (!out_valid && !stall && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bubble_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_instr  = out_valid ? head[WIDTH+PC_W-1:PC_W] : NOP;
    assign out_pc     = out_valid ? head[PC_W-1:0] : '0;
    assign count      = count_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: queue scoreboard checked every
// cycle, a table of fill/drain vectors, and hand-written corner sequences.
module tb_instr_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;
    logic [3:0]  bubble_cnt;

    instr_fetch_buffer #(
        .WIDTH (32),
        .PC_W  (32),
        .DEPTH (DEPTH),
        .NOP   (32'h0000_0000),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .count      (count),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic        iv;
        logic        st;
        logic [31:0] instr;
        logic [31:0] pc;
        int          exp_count;
        logic        exp_ready;
    } vec_t;

    ent_t       sb[$];
    logic [3:0] m_bub;
    int         nvec = 0;
    int         nmis = 0;
    vec_t       tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        ent_t h;
        h = (sb.size() != 0) ? sb[0] : '0;
        chk("count", 64'(count), 64'(sb.size()));
        chk("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("out_instr", 64'(out_instr), 64'(h.instr));
        chk("out_pc", 64'(out_pc), 64'(h.pc));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    endtask

    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl);
        logic m_push, m_pop, m_bubble;
        in_valid = iv;
        in_instr = ins;
        in_pc    = pc;
        stall    = st;
        flush    = fl;
        m_push   = iv && (sb.size() < DEPTH) && !fl;
        m_pop    = (sb.size() != 0) && !st && !fl;
        m_bubble = (sb.size() == 0) && !st;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) sb.push_back({ins, pc});
        end
        if (m_bubble && m_bub != 4'hF) m_bub = m_bub + 4'd1;
        check_model();
    endtask

    task automatic reset_dut(input logic iv, input logic fl);
        reset    = 1'b1;
        in_valid = iv;
        in_instr = 32'hFFFF_FFFF;
        in_pc    = 32'h0000_FFFC;
        stall    = 1'b0;
        flush    = fl;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        m_bub = '0;
        check_model();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
        chk({tag, "_out_pc"}, 64'(out_pc), 64'd0);
        chk({tag, "_bubble"}, 64'(bubble_cnt), 64'd0);
    endtask

    initial begin
        // Fill with stall held (5th word refused), drain, then a second fill to wrap pointers.
        for (int i = 0; i < 5; i++) begin
            tbl[i] = '{1'b1, 1'b1, 32'hA000_0000 + 32'(i), 32'h0000_0100 + 32'(4 * i),
                       (i < 4) ? i + 1 : 4, (i < 3)};
        end
        for (int i = 0; i < 4; i++) begin
            tbl[5 + i] = '{1'b0, 1'b0, 32'h0, 32'h0, 3 - i, 1'b1};
        end
        for (int i = 0; i < 4; i++) begin
            tbl[9 + i] = '{1'b1, 1'b1, 32'hB000_0000 + 32'(i), 32'h0000_0200 + 32'(4 * i),
                           i + 1, (i < 3)};
        end
        for (int i = 0; i < 4; i++) begin
            tbl[13 + i] = '{1'b0, 1'b0, 32'h0, 32'h0, 3 - i, 1'b1};
        end

        reset_dut(1'b0, 1'b0);
        chk_reset_values("reset");

        repeat (5) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("idle_bubble", 64'(bubble_cnt), 64'd5);
        chk("idle_out_instr", 64'(out_instr), 64'd0);

        cycle(1'b1, 32'h8C01_0004, 32'h0000_3000, 1'b0, 1'b0);
        chk("single_instr", 64'(out_instr), 64'h8C01_0004);
        chk("single_pc", 64'(out_pc), 64'h3000);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("single_popped", 64'(count), 64'd0);

        for (int i = 0; i < 17; i++) begin
            if (i == 5) chk("drain_head_pc", 64'(out_pc), 64'h100);
            if (i == 13) chk("wrap_head_pc", 64'(out_pc), 64'h200);
            cycle(tbl[i].iv, tbl[i].instr, tbl[i].pc, tbl[i].st, 1'b0);
            chk("tbl_count", 64'(count), 64'(tbl[i].exp_count));
            chk("tbl_ready", 64'(in_ready), 64'(tbl[i].exp_ready));
        end

        // Flush with a simultaneous push: the pushed word must vanish.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'hC000_0000 + 32'(i), 32'h0000_0400 + 32'(4 * i), 1'b1, 1'b0);
        end
        cycle(1'b1, 32'hDEAD_BEEF, 32'h0000_0500, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_instr", 64'(out_instr), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flush_lost", 64'(out_valid), 64'd0);

        // Steady state at occupancy 2 with a push and a pop every cycle.
        cycle(1'b1, 32'hE000_0000, 32'h0000_0600, 1'b1, 1'b0);
        cycle(1'b1, 32'hE000_0001, 32'h0000_0604, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("stream_pc", 64'(out_pc), 64'(32'h600 + 32'(4 * i)));
            cycle(1'b1, 32'hE000_0002 + 32'(i), 32'h0000_0608 + 32'(4 * i), 1'b0, 1'b0);
            chk("stream_count", 64'(count), 64'd2);
        end
        repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Bubble counter saturation over 2^CNT_W+3 bubble cycles.
        reset_dut(1'b0, 1'b0);
        repeat ((1 << CNT_W) + 3) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("bubble_sat", 64'(bubble_cnt), 64'hF);

        // Reset mid-fill, with push and flush requested in the same cycle.
        cycle(1'b1, 32'hF000_0000, 32'h0000_0700, 1'b1, 1'b0);
        cycle(1'b1, 32'hF000_0001, 32'h0000_0704, 1'b1, 1'b0);
        reset_dut(1'b1, 1'b1);
        chk_reset_values("midreset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
